// File: rtl/matrix_packet_pkg.sv
// Shared definitions for the matrix packetizer.
//   SYNC_BYTE    : sync constant placed in the top byte of every header.
//   Header entry : 24-bit queue entry {position[23:16], length[15:8], 7'b0, end[0]}.
//                  The emitted header word is {SYNC_BYTE, entry}.
//   state_e      : output FSM states.
package matrix_packet_pkg;

  localparam logic [7:0] SYNC_BYTE   = 8'hA5;
  localparam int         HQ_W        = 24;
  localparam int         HDR_POS_LSB = 16;
  localparam int         HDR_LEN_LSB = 8;
  localparam int         HDR_END_BIT = 0;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_HEADER   = 2'd1,
    ST_PAYLOAD  = 2'd2,
    ST_CHECKSUM = 2'd3
  } state_e;

  function automatic logic [HQ_W-1:0] make_hdr(input logic [7:0] pos,
                                               input logic [7:0] len,
                                               input logic       last);
    logic [HQ_W-1:0] h;
    h                    = '0;
    h[HDR_POS_LSB +: 8]  = pos;
    h[HDR_LEN_LSB +: 8]  = len;
    h[HDR_END_BIT]       = last;
    return h;
  endfunction

  function automatic logic [7:0] hdr_len(input logic [HQ_W-1:0] h);
    return h[HDR_LEN_LSB +: 8];
  endfunction

endpackage

// File: rtl/matrix_word_fifo.sv
// Synchronous first-word-fall-through FIFO.
//   clk, resetn     : clock, asynchronous active-low reset (pointers only)
//   push, wr_data   : write request and data; accepted when not full, or
//                     when full and a pop happens in the same cycle
//   pop, rd_data    : read request; rd_data always shows the head entry
//   full, empty     : occupancy flags
module matrix_word_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 16
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             push,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             pop,
  output logic [WIDTH-1:0] rd_data,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] PTR_ONE = 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic             do_push;
  logic             do_pop;

  always_comb begin
    empty   = (wr_ptr == rd_ptr);
    full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    do_pop  = pop && !empty;
    do_push = push && (!full || do_pop);
    rd_data = mem[rd_ptr[AW-1:0]];
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_ONE;
      if (do_pop)  rd_ptr <= rd_ptr + PTR_ONE;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= wr_data;
  end

endmodule

// File: rtl/matrix_packetizer.sv
// Matrix packetizer: collects CPU matrix words into rows and emits each row
// as a packet (header, payload words[, checksum]) on a valid/ready stream.
//   clk, resetn                      : clock, asynchronous active-low reset
//   in_matrix, in_matrix_en          : matrix word and its strobe
//   in_matrix_end_row, in_matrix_end : row / matrix close strobes
//   in_position, in_position_en      : destination position and load strobe
//   pkt_data, pkt_valid, pkt_last,
//   pkt_ready                        : registered packet stream
//   overflow                         : sticky drop flag (word or header)
//   busy                             : data held or packet in progress
// Build option: define MATRIX_PACKET_CHECKSUM_EN to append an XOR checksum
// beat (header ^ payload words) carrying pkt_last.
module matrix_packetizer
  import matrix_packet_pkg::*;
#(
  parameter int FIFO_DEPTH = 16,
  parameter int HDR_DEPTH  = FIFO_DEPTH
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic [31:0] in_matrix,
  input  logic        in_matrix_en,
  input  logic        in_matrix_end_row,
  input  logic        in_matrix_end,
  input  logic [7:0]  in_position,
  input  logic        in_position_en,
  output logic [31:0] pkt_data,
  output logic        pkt_valid,
  output logic        pkt_last,
  input  logic        pkt_ready,
  output logic        overflow,
  output logic        busy
);

`ifdef MATRIX_PACKET_CHECKSUM_EN
  localparam logic CHK_EN = 1'b1;
`else
  localparam logic CHK_EN = 1'b0;
`endif

  state_e          state;
  logic [7:0]      position;
  logic [7:0]      row_len;
  logic [7:0]      cnt;
`ifdef MATRIX_PACKET_CHECKSUM_EN
  logic [31:0]     csum;
`endif

  logic            hs;
  logic            pf_pop, pf_full, pf_empty, word_acc;
  logic [31:0]     pf_rd;
  logic            hq_push, hq_pop, hq_full, hq_empty, commit;
  logic [HQ_W-1:0] hq_wr, hq_rd;
  logic [7:0]      commit_len;
  logic [7:0]      commit_pos;

  // A word strobed with a close strobe belongs to the row being closed, so
  // the committed length already counts it. A pop in the same cycle frees a
  // slot, letting a word into a full FIFO without loss.
  always_comb begin
    hs         = pkt_valid && pkt_ready;
    pf_pop     = hs && ((state == ST_HEADER) || (state == ST_PAYLOAD)) && (cnt != '0);
    word_acc   = in_matrix_en && (!pf_full || pf_pop);
    commit_len = row_len + {7'b0, word_acc};
    commit_pos = in_position_en ? in_position : position;
    commit     = in_matrix_end || (in_matrix_end_row && (commit_len != '0));
    hq_wr      = make_hdr(commit_pos, commit_len, in_matrix_end);
    hq_pop     = (state == ST_IDLE) && !hq_empty;
    hq_push    = commit && (!hq_full || hq_pop);
    busy       = !pf_empty || !hq_empty || (state != ST_IDLE);
  end

  matrix_word_fifo #(.WIDTH(32), .DEPTH(FIFO_DEPTH)) u_payload_fifo (
    .clk     (clk),
    .resetn  (resetn),
    .push    (word_acc),
    .wr_data (in_matrix),
    .pop     (pf_pop),
    .rd_data (pf_rd),
    .full    (pf_full),
    .empty   (pf_empty)
  );

  matrix_word_fifo #(.WIDTH(HQ_W), .DEPTH(HDR_DEPTH)) u_header_queue (
    .clk     (clk),
    .resetn  (resetn),
    .push    (hq_push),
    .wr_data (hq_wr),
    .pop     (hq_pop),
    .rd_data (hq_rd),
    .full    (hq_full),
    .empty   (hq_empty)
  );

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      position <= '0;
      row_len  <= '0;
      overflow <= 1'b0;
    end else begin
      if (in_position_en) position <= in_position;
      if (commit)         row_len  <= '0;
      else if (word_acc)  row_len  <= commit_len;
      if ((in_matrix_en && !word_acc) || (commit && !hq_push)) overflow <= 1'b1;
    end
  end

  // cnt holds the payload words still to be loaded into the output register;
  // HEADER and PAYLOAD share the load path.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state     <= ST_IDLE;
      cnt       <= '0;
      pkt_data  <= '0;
      pkt_valid <= 1'b0;
      pkt_last  <= 1'b0;
`ifdef MATRIX_PACKET_CHECKSUM_EN
      csum      <= '0;
`endif
    end else begin
      case (state)
        ST_IDLE: begin
          if (!hq_empty) begin
            pkt_data  <= {SYNC_BYTE, hq_rd};
            pkt_valid <= 1'b1;
            pkt_last  <= (hdr_len(hq_rd) == '0) && !CHK_EN;
            cnt       <= hdr_len(hq_rd);
            state     <= ST_HEADER;
`ifdef MATRIX_PACKET_CHECKSUM_EN
            csum      <= {SYNC_BYTE, hq_rd};
`endif
          end
        end
        ST_HEADER, ST_PAYLOAD: begin
          if (hs) begin
            if (cnt != '0) begin
              pkt_data <= pf_rd;
              pkt_last <= (cnt == 8'd1) && !CHK_EN;
              cnt      <= cnt - 8'd1;
              state    <= ST_PAYLOAD;
`ifdef MATRIX_PACKET_CHECKSUM_EN
              csum     <= csum ^ pf_rd;
`endif
            end else begin
`ifdef MATRIX_PACKET_CHECKSUM_EN
              pkt_data <= csum;
              pkt_last <= 1'b1;
              state    <= ST_CHECKSUM;
`else
              pkt_valid <= 1'b0;
              pkt_last  <= 1'b0;
              state     <= ST_IDLE;
`endif
            end
          end
        end
`ifdef MATRIX_PACKET_CHECKSUM_EN
        ST_CHECKSUM: begin
          if (hs) begin
            pkt_valid <= 1'b0;
            pkt_last  <= 1'b0;
            state     <= ST_IDLE;
          end
        end
`endif
        default: begin
          pkt_valid <= 1'b0;
          pkt_last  <= 1'b0;
          state     <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_matrix_packetizer.sv
// Directed testbench for matrix_packetizer. Expected beats are hand-computed;
// checksum beats are expected only when MATRIX_PACKET_CHECKSUM_EN is defined.
module tb_matrix_packetizer;

`ifdef MATRIX_PACKET_CHECKSUM_EN
  localparam logic CHK = 1'b1;
`else
  localparam logic CHK = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic [31:0] in_matrix = '0;
  logic        in_matrix_en = 1'b0;
  logic        in_matrix_end_row = 1'b0;
  logic        in_matrix_end = 1'b0;
  logic [7:0]  in_position = '0;
  logic        in_position_en = 1'b0;
  logic [31:0] pkt_data;
  logic        pkt_valid;
  logic        pkt_last;
  logic        pkt_ready = 1'b0;
  logic        overflow;
  logic        busy;

  int unsigned n_cmp = 0;
  int unsigned n_err = 0;
  logic [32:0] beats[$];
  logic [32:0] expq[$];
  logic        stalled = 1'b0;
  logic [32:0] held = '0;
  int unsigned n_before;

  matrix_packetizer #(.FIFO_DEPTH(16)) dut (
    .clk               (clk),
    .resetn            (resetn),
    .in_matrix         (in_matrix),
    .in_matrix_en      (in_matrix_en),
    .in_matrix_end_row (in_matrix_end_row),
    .in_matrix_end     (in_matrix_end),
    .in_position       (in_position),
    .in_position_en    (in_position_en),
    .pkt_data          (pkt_data),
    .pkt_valid         (pkt_valid),
    .pkt_last          (pkt_last),
    .pkt_ready         (pkt_ready),
    .overflow          (overflow),
    .busy              (busy)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [32:0] got, input logic [32:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Beats are recorded and stall stability is checked mid-cycle, away from
  // the rising edge where the inputs and registered outputs change.
  always @(negedge clk) begin
    if (!resetn) begin
      stalled = 1'b0;
    end else begin
      if (stalled) begin
        check_eq("stall_valid", {32'b0, pkt_valid}, 33'd1);
        check_eq("stall_hold", {pkt_last, pkt_data}, held);
      end
      if (pkt_valid && pkt_ready) beats.push_back({pkt_last, pkt_data});
      stalled = pkt_valid && !pkt_ready;
      held    = {pkt_last, pkt_data};
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_word(input logic [31:0] w);
    in_matrix    = w;
    in_matrix_en = 1'b1;
    tick();
    in_matrix_en = 1'b0;
  endtask

  task automatic load_pos(input logic [7:0] p);
    in_position    = p;
    in_position_en = 1'b1;
    tick();
    in_position_en = 1'b0;
  endtask

  task automatic wait_idle(input int unsigned budget);
    int unsigned k = 0;
    while ((busy || pkt_valid) && k < budget) begin
      tick();
      k++;
    end
    check_eq("idle_reached", {32'b0, busy}, 33'd0);
  endtask

  task automatic add_exp(input logic [31:0] d, input logic l);
    expq.push_back({l, d});
  endtask

  task automatic check_pkt(input string tag);
    check_eq({tag, "_count"}, 33'(beats.size()), 33'(expq.size()));
    for (int i = 0; i < expq.size() && i < beats.size(); i++)
      check_eq($sformatf("%s_beat%0d", tag, i), beats[i], expq[i]);
    beats.delete();
    expq.delete();
  endtask

  initial begin
    // Reset values
    repeat (2) tick();
    check_eq("rst_valid", {32'b0, pkt_valid}, 33'd0);
    check_eq("rst_last",  {32'b0, pkt_last},  33'd0);
    check_eq("rst_data",  {1'b0, pkt_data},   33'd0);
    check_eq("rst_ovf",   {32'b0, overflow},  33'd0);
    check_eq("rst_busy",  {32'b0, busy},      33'd0);
    resetn = 1'b1;
    tick();

    // Position 3, words 1,2,3, end_row; header latency measured from the commit edge
    pkt_ready = 1'b1;
    beats.delete();
    load_pos(8'd3);
    send_word(32'd1);
    send_word(32'd2);
    send_word(32'd3);
    in_matrix_end_row = 1'b1;
    tick();
    in_matrix_end_row = 1'b0;
    check_eq("lat_e_valid", {32'b0, pkt_valid}, 33'd0);
    tick();
    check_eq("lat_e1_valid", {32'b0, pkt_valid}, 33'd1);
    check_eq("lat_e1_hdr", {1'b0, pkt_data}, {1'b0, 32'hA503_0300});
    wait_idle(50);
    add_exp(32'hA503_0300, 1'b0);
    add_exp(32'd1, 1'b0);
    add_exp(32'd2, 1'b0);
    add_exp(32'd3, !CHK);
    if (CHK) add_exp(32'hA503_0300, 1'b1);
    check_pkt("row3");

    // Header-only END, position loaded in the same cycle
    in_position       = 8'd7;
    in_position_en    = 1'b1;
    in_matrix_end     = 1'b1;
    tick();
    in_position_en    = 1'b0;
    in_matrix_end     = 1'b0;
    wait_idle(50);
    add_exp(32'hA507_0001, !CHK);
    if (CHK) add_exp(32'hA507_0001, 1'b1);
    check_pkt("hdr_only");

    // Word together with end_row+end: single END commit, word included
    load_pos(8'd5);
    send_word(32'h11);
    in_matrix         = 32'h22;
    in_matrix_en      = 1'b1;
    in_matrix_end_row = 1'b1;
    in_matrix_end     = 1'b1;
    tick();
    in_matrix_en      = 1'b0;
    in_matrix_end_row = 1'b0;
    in_matrix_end     = 1'b0;
    wait_idle(50);
    add_exp(32'hA505_0201, 1'b0);
    add_exp(32'h11, 1'b0);
    add_exp(32'h22, !CHK);
    if (CHK) add_exp(32'hA505_0232, 1'b1);
    check_pkt("end_both");

    // end_row on an empty row does nothing
    in_matrix_end_row = 1'b1;
    tick();
    in_matrix_end_row = 1'b0;
    repeat (3) tick();
    check_eq("empty_row_busy",  {32'b0, busy},      33'd0);
    check_eq("empty_row_valid", {32'b0, pkt_valid}, 33'd0);
    check_eq("empty_row_beats", 33'(beats.size()),  33'd0);

    // 17 words into a depth-16 FIFO while stalled
    pkt_ready = 1'b0;
    load_pos(8'd2);
    for (int i = 1; i <= 16; i++) send_word(32'h100 + 32'(i));
    check_eq("ovf_at_16", {32'b0, overflow}, 33'd0);
    send_word(32'h111);
    check_eq("ovf_at_17", {32'b0, overflow}, 33'd1);
    in_matrix_end_row = 1'b1;
    tick();
    in_matrix_end_row = 1'b0;
    repeat (3) tick();
    check_eq("ovf_hdr_valid", {32'b0, pkt_valid}, 33'd1);
    check_eq("ovf_hdr", {1'b0, pkt_data}, {1'b0, 32'hA502_1000});
    pkt_ready = 1'b1;
    wait_idle(100);
    add_exp(32'hA502_1000, 1'b0);
    for (int i = 1; i <= 16; i++) add_exp(32'h100 + 32'(i), (i == 16) && !CHK);
    if (CHK) add_exp(32'hA502_1010, 1'b1);
    check_pkt("ovf");
    check_eq("ovf_sticky", {32'b0, overflow}, 33'd1);

    // Random back-pressure during a 4-word row
    pkt_ready = 1'b0;
    load_pos(8'd9);
    send_word(32'hA1);
    send_word(32'hA2);
    send_word(32'hA3);
    send_word(32'hA4);
    in_matrix_end_row = 1'b1;
    tick();
    in_matrix_end_row = 1'b0;
    for (int k = 0; k < 300 && (busy || pkt_valid); k++) begin
      pkt_ready = 1'($urandom_range(0, 1));
      tick();
    end
    pkt_ready = 1'b1;
    wait_idle(20);
    add_exp(32'hA509_0400, 1'b0);
    add_exp(32'hA1, 1'b0);
    add_exp(32'hA2, 1'b0);
    add_exp(32'hA3, 1'b0);
    add_exp(32'hA4, !CHK);
    if (CHK) add_exp(32'hA509_0404, 1'b1);
    check_pkt("rand_ready");

    // Reset asserted mid-payload (overflow still set from above)
    pkt_ready = 1'b0;
    load_pos(8'd1);
    for (int i = 1; i <= 4; i++) send_word(32'(i));
    in_matrix_end_row = 1'b1;
    tick();
    in_matrix_end_row = 1'b0;
    for (int k = 0; k < 20 && !pkt_valid; k++) tick();
    check_eq("mid_hdr_up", {32'b0, pkt_valid}, 33'd1);
    pkt_ready = 1'b1;
    tick();
    tick();
    pkt_ready = 1'b0;
    n_before = beats.size();
    #3 resetn = 1'b0;
    #1;
    check_eq("mid_rst_valid", {32'b0, pkt_valid}, 33'd0);
    check_eq("mid_rst_ovf",   {32'b0, overflow},  33'd0);
    check_eq("mid_rst_busy",  {32'b0, busy},      33'd0);
    check_eq("mid_rst_data",  {1'b0, pkt_data},   33'd0);
    repeat (2) tick();
    resetn    = 1'b1;
    pkt_ready = 1'b1;
    repeat (20) tick();
    check_eq("post_rst_beats", 33'(beats.size()), 33'(n_before));
    check_eq("post_rst_busy",  {32'b0, busy},      33'd0);
    check_eq("post_rst_valid", {32'b0, pkt_valid}, 33'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
